// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned INSTR_BITS  = 32;

  localparam logic [PC_WIDTH-1:0]   RESET_VECTOR = 32'hBFC00000;
  localparam logic [INSTR_BITS-1:0] NOP_INSTR    = 32'h00000013;

  // One buffered fetch: the instruction and the PC it was read from.
  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INSTR_BITS-1:0] instr;
  } fetch_entry_t;

  // Queue occupancy; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } qstate_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries with push/pop and a dominant flush.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  qstate_e      state_q, state_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         do_push;
  logic         do_pop;

  // State, pointer and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= Q_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Next occupancy, pointers and storage; flush empties without writing.
  always_comb begin
    do_pop   = pop_i && (state_q != Q_EMPTY);
    do_push  = push_i && ((state_q != Q_FULL) || do_pop);
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush_i) begin
      state_d  = Q_EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
      end
      wr_ptr_d = wr_ptr_q ^ do_push;
      rd_ptr_d = rd_ptr_q ^ do_pop;
      unique case (state_q)
        Q_EMPTY: if (do_push)            state_d = Q_ONE;
        Q_ONE: begin
          if (do_push && !do_pop)        state_d = Q_FULL;
          else if (do_pop && !do_push)   state_d = Q_EMPTY;
        end
        Q_FULL:  if (do_pop && !do_push) state_d = Q_ONE;
        default:                         state_d = Q_EMPTY;
      endcase
    end
  end

  // Head entry and occupancy flags.
  always_comb begin
    head_o  = mem_q[rd_ptr_q];
    valid_o = (state_q != Q_EMPTY);
    count_o = state_q;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, ROM addressing, 2-entry
// fetch queue toward decode, and redirect handling.
module fetch_unit #(
  parameter int unsigned               ADDRESS_WIDTH = 32,
  parameter int unsigned               INSTR_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_VECTOR  = fetch_pkg::RESET_VECTOR,
  parameter int unsigned               DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic [INSTR_WIDTH-1:0]   imem_instr_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [INSTR_WIDTH-1:0]   instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_o
);

  import fetch_pkg::*;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     pop;
  logic                     push;
  fetch_entry_t             wr_entry;
  fetch_entry_t             head;
  logic                     q_valid;
  logic [1:0]               q_count;

  fetch_queue u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .head_o  (head),
    .valid_o (q_valid),
    .count_o (q_count)
  );

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  // Handshake, push decision and next PC; redirect wins over fetch.
  always_comb begin
    pop            = q_valid && ready_i;
    push           = !redirect_i && ((32'(q_count) < DEPTH) || pop);
    wr_entry.pc    = pc_q;
    wr_entry.instr = imem_instr_i;
    pc_d           = pc_q;
    if (redirect_i)  pc_d = redirect_pc_i & ~ADDRESS_WIDTH'(3);
    else if (push)   pc_d = pc_q + ADDRESS_WIDTH'(4);
  end

  // Decode-facing outputs; an empty queue shows a NOP at PC 0.
  always_comb begin
    imem_addr_o = pc_q;
    valid_o     = q_valid;
    if (q_valid) begin
      instr_o = head.instr;
      pc_o    = head.pc;
    end else begin
      instr_o = NOP_INSTR;
      pc_o    = '0;
    end
    pc_plus4_o = pc_o + ADDRESS_WIDTH'(4);
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the CPU. It holds the program counter and drives the instruction ROM address, taking the ROM's combinational read back in the same cycle. It buffers fetched instructions, each paired with its PC, in a 2-entry queue and hands them to decode over a valid/ready handshake. Branch, jump and exception redirects flush the queue and restart fetch at the target.

## Interface
Parameters:
- ADDRESS_WIDTH, 32: PC/address width.
- INSTR_WIDTH, 32: instruction width.
- RESET_VECTOR, 32'hBFC00000: PC after reset; base of instruction ROM.
- DEPTH, 2: instruction queue entries; only 2 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_i  in  1  flush queue and load PC from redirect_pc_i.
- redirect_pc_i  in  ADDRESS_WIDTH  redirect target; bits [1:0] ignored.
- imem_addr_o  out  ADDRESS_WIDTH  ROM byte address; always equals pc_q.
- imem_instr_i  in  INSTR_WIDTH  ROM read data, combinational from imem_addr_o.
- valid_o  out  1  head entry valid.
- ready_i  in  1  decode accepts head entry.
- instr_o  out  INSTR_WIDTH  head instruction.
- pc_o  out  ADDRESS_WIDTH  head PC.
- pc_plus4_o  out  ADDRESS_WIDTH  pc_o + 4, modulo 2^32.

## Operation
- pop = valid_o & ready_i.
- push = !redirect_i & (count < 2 | pop). A push writes {pc_q, imem_instr_i} at the write pointer and sets pc_q <= pc_q + 4.
- pc_q holds when there is no push and no redirect, so imem_addr_o is stable under backpressure.
- Redirect has priority over everything else:
  - count <= 0, both pointers <= 0.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - No push that cycle.
  - A pop coincident with the redirect still counts as a completed handshake.
- Queue state is count ∈ {0,1,2}, i.e. EMPTY/ONE/FULL, with 1-bit read and write pointers.
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE.
  - FULL: pop -> ONE, plus a push in the same cycle -> FULL.
- valid_o = (count != 0).
- When EMPTY: instr_o = 32'h00000013 (NOP), pc_o = 0, pc_plus4_o = 4.
- PC arithmetic is unsigned and wraps: 32'hFFFFFFFC + 4 = 32'h00000000.
- No range checking against the ROM window; an out-of-window fetch is the ROM's problem.

## Timing
- Reset values (asserted asynchronously, no clock needed):
  - pc_q = imem_addr_o = RESET_VECTOR.
  - count = 0, valid_o = 0.
  - instr_o = NOP, pc_o = 0.
- Fetch-to-decode latency is 1 cycle. An instruction addressed in cycle N is presented on valid_o/instr_o after edge N.
- With ready_i held high, throughput is 1 instruction per cycle.
- First valid_o after rst deasserts: the first rising edge.
- Redirect sampled at edge N: valid_o is 0 after N; the target instruction is valid after edge N+1 (1 bubble).
- Backpressure: after ready_i drops, at most 2 further entries are accepted; then pc_q freezes.
- Reset mid-stream discards all queued entries immediately.

## Structure
- Package fetch_pkg holds:
  - RESET_VECTOR and NOP_INSTR (32'h00000013) constants.
  - typedef struct packed fetch_entry_t {pc, instr}.
- Sub-module fetch_queue: the 2-entry FIFO of fetch_entry_t, with push/pop/flush inputs, exposing head, valid and count.
- fetch_unit itself holds pc_q, the push logic, the redirect logic and the NOP/zero output mux.
- The top level connects imem_addr_o to instr_mem addr_i and instr_mem instr_o to imem_instr_i.

## Test plan
- Reset then ready_i=1, ROM loaded with words 0x11111111, 0x22222222, 0x33333333 -> pc_o sequence BFC00000/BFC00004/BFC00008 with matching instr_o, valid_o high from the first edge.
- ready_i=0 for 5 cycles after the first fetch -> count reaches 2, imem_addr_o frozen at BFC00008. Then ready_i=1 -> instructions at BFC00000, 04, 08, 0C in order, no duplicate or gap.
- Queue FULL, redirect_i=1 to BFC00100 -> valid_o=0 next cycle, next valid entry has pc_o=BFC00100, stale entries never appear.
- Redirect to BFC00102 -> fetch address BFC00100; redirect coincident with pop -> queue empty afterwards, pc_q = target.
- rst asserted between edges mid-stream -> valid_o=0, imem_addr_o=BFC00000 immediately; first entry after release has pc_o=BFC00000.
- Redirect to FFFFFFFC with ready_i=1 -> pc_o FFFFFFFC then 00000000; pc_plus4_o 00000000 then 00000004.
